// File: rtl/friscv_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester identity.
package friscv_pkg;

   localparam int unsigned ARCH = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_ACK  = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter_2
   import friscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       grant_en,
   output req_id_t    grant
);

   req_id_t last_grant_q;
   req_id_t last_grant_d;

   // req[0] is the fetch port, req[1] the data port
   always_comb begin
      case (req)
         2'b10:   grant = REQ_DM;
         2'b11:   grant = (last_grant_q == REQ_IF) ? REQ_DM : REQ_IF;
         default: grant = REQ_IF;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_en) begin
         last_grant_d = grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= REQ_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// one transaction in flight, with a stall back to the core until its access completes.
module mem_arbiter
   import friscv_pkg::*;
#(
   parameter int unsigned ADDR_W = ARCH,
   parameter int unsigned DATA_W = ARCH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_in,
   input  logic [ADDR_W-1:0]     if_addr_in,
   output logic [DATA_W-1:0]     if_rdata_out,
   output logic                  if_ack_out,
   input  logic                  dm_req_in,
   input  logic                  dm_we_in,
   input  logic [ADDR_W-1:0]     dm_addr_in,
   input  logic [DATA_W-1:0]     dm_wdata_in,
   input  logic [DATA_W/8-1:0]   dm_be_in,
   output logic [DATA_W-1:0]     dm_rdata_out,
   output logic                  dm_ack_out,
   output logic                  mem_req_out,
   output logic                  mem_we_out,
   output logic [ADDR_W-1:0]     mem_addr_out,
   output logic [DATA_W-1:0]     mem_wdata_out,
   output logic [DATA_W/8-1:0]   mem_be_out,
   input  logic                  mem_gnt_in,
   input  logic                  mem_rvalid_in,
   input  logic [DATA_W-1:0]     mem_rdata_in,
   output logic                  stall_out
);

   arb_state_t            state_q,     state_d;
   req_id_t               owner_q,     owner_d;
   logic                  mem_req_q,   mem_req_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DATA_W/8-1:0]   mem_be_q,    mem_be_d;
   logic [DATA_W-1:0]     if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0]     dm_rdata_q,  dm_rdata_d;

   logic    grant_en;
   req_id_t grant;

   // Arbitrate only from IDLE; in ACK the finished owner's req is still high.
   assign grant_en = (state_q == ARB_IDLE) && (if_req_in || dm_req_in);

   rr_arbiter_2 u_rr_arbiter_2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      ({dm_req_in, if_req_in}),
      .grant_en (grant_en),
      .grant    (grant)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_en) begin
               owner_d   = grant;
               mem_req_d = 1'b1;
               state_d   = ARB_REQ;
               if (grant == REQ_DM) begin
                  mem_we_d    = dm_we_in;
                  mem_addr_d  = dm_addr_in;
                  mem_wdata_d = dm_wdata_in;
                  mem_be_d    = dm_be_in;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr_in;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
               end
            end
         end
         ARB_REQ: begin
            if (mem_gnt_in) begin
               mem_req_d = 1'b0;
               state_d   = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (mem_rvalid_in) begin
               if (owner_q == REQ_DM) begin
                  dm_rdata_d = mem_rdata_in;
               end else begin
                  if_rdata_d = mem_rdata_in;
               end
               state_d = ARB_ACK;
            end
         end
         ARB_ACK:  state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         owner_q     <= REQ_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign mem_req_out   = mem_req_q;
   assign mem_we_out    = mem_we_q;
   assign mem_addr_out  = mem_addr_q;
   assign mem_wdata_out = mem_wdata_q;
   assign mem_be_out    = mem_be_q;
   assign if_rdata_out  = if_rdata_q;
   assign dm_rdata_out  = dm_rdata_q;

   assign if_ack_out = (state_q == ARB_ACK) && (owner_q == REQ_IF);
   assign dm_ack_out = (state_q == ARB_ACK) && (owner_q == REQ_DM);

   assign stall_out = (if_req_in & ~if_ack_out) | (dm_req_in & ~dm_ack_out);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory with programmable gnt/rvalid delays
// checks each memory request, and a monitor checks each ack against the queued expectation.
module tb_mem_arbiter;
   import friscv_pkg::*;

   localparam logic [31:0] WR_RESP = 32'h0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_in = 1'b0;
   logic [31:0] if_addr_in = '0;
   logic [31:0] if_rdata_out;
   logic        if_ack_out;
   logic        dm_req_in = 1'b0;
   logic        dm_we_in = 1'b0;
   logic [31:0] dm_addr_in = '0;
   logic [31:0] dm_wdata_in = '0;
   logic [3:0]  dm_be_in = '0;
   logic [31:0] dm_rdata_out;
   logic        dm_ack_out;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_wdata_out;
   logic [3:0]  mem_be_out;
   logic        mem_gnt_in = 1'b0;
   logic        mem_rvalid_in = 1'b0;
   logic [31:0] mem_rdata_in = '0;
   logic        stall_out;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_in     (if_req_in),
      .if_addr_in    (if_addr_in),
      .if_rdata_out  (if_rdata_out),
      .if_ack_out    (if_ack_out),
      .dm_req_in     (dm_req_in),
      .dm_we_in      (dm_we_in),
      .dm_addr_in    (dm_addr_in),
      .dm_wdata_in   (dm_wdata_in),
      .dm_be_in      (dm_be_in),
      .dm_rdata_out  (dm_rdata_out),
      .dm_ack_out    (dm_ack_out),
      .mem_req_out   (mem_req_out),
      .mem_we_out    (mem_we_out),
      .mem_addr_out  (mem_addr_out),
      .mem_wdata_out (mem_wdata_out),
      .mem_be_out    (mem_be_out),
      .mem_gnt_in    (mem_gnt_in),
      .mem_rvalid_in (mem_rvalid_in),
      .mem_rdata_in  (mem_rdata_in),
      .stall_out     (stall_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      req_id_t     id;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } txn_t;

   txn_t        exp_mem_q[$];
   txn_t        exp_ack_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] mdl_mem[logic [31:0]];

   int          n_chk = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   int unsigned rv_cyc = 0;
   int unsigned gnt_delay = 0;
   int unsigned rv_delay = 0;
   bit          stray_rv = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'd7) ^ 32'h3C00_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a] = d;
      mdl_mem[a] = d;
   endtask

   task automatic push(input req_id_t id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
      txn_t        t;
      logic [31:0] cur;
      cur     = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
      t.id    = id;
      t.we    = (id == REQ_DM) ? we : 1'b0;
      t.addr  = addr;
      t.wdata = wdata;
      t.be    = (id == REQ_DM) ? be : 4'hF;
      t.rdata = t.we ? WR_RESP : cur;
      if (t.we) ref_mem[addr] = merge(cur, wdata, be);
      exp_mem_q.push_back(t);
      exp_ack_q.push_back(t);
   endtask

   task automatic drive(input req_id_t id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      push(id, we, addr, wdata, be);
      if (id == REQ_IF) begin
         if_req_in  = 1'b1;
         if_addr_in = addr;
      end else begin
         dm_req_in   = 1'b1;
         dm_we_in    = we;
         dm_addr_in  = addr;
         dm_wdata_in = wdata;
         dm_be_in    = be;
      end
   endtask

   // Called on a negedge; holds req until the ack is seen, then drops it in that same cycle.
   task automatic do_req(input req_id_t id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
      bit done;
      done = 1'b0;
      drive(id, we, addr, wdata, be);
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if ((id == REQ_IF) ? if_ack_out : dm_ack_out) begin
            done = 1'b1;
            if (id == REQ_IF) if_req_in = 1'b0;
            else              dm_req_in = 1'b0;
         end
      end
      chk("req_done", 64'(done), 64'd1);
   endtask

   // Memory model
   initial begin : responder
      bit          in_req;
      bit          rv_pend;
      int unsigned gcnt;
      int unsigned rcnt;
      logic [31:0] a0;
      logic [31:0] rdv;
      logic [31:0] cur;
      txn_t        t;
      in_req  = 1'b0;
      rv_pend = 1'b0;
      gcnt    = 0;
      rcnt    = 0;
      a0      = '0;
      rdv     = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         mem_gnt_in    = 1'b0;
         mem_rvalid_in = 1'b0;
         if (!rst_n) in_req = 1'b0;
         if (stray_rv) begin
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = 32'hFEED_FACE;
            stray_rv      = 1'b0;
         end else if (rv_pend) begin
            if (rcnt == 0) begin
               mem_rvalid_in = 1'b1;
               mem_rdata_in  = rdv;
               rv_pend       = 1'b0;
               rv_cyc        = cyc;
            end else begin
               rcnt--;
            end
         end else if (rst_n && (in_req || mem_req_out)) begin
            if (!in_req) begin
               in_req = 1'b1;
               gcnt   = gnt_delay;
               a0     = mem_addr_out;
            end
            chk("mreq_held", 64'(mem_req_out), 64'd1);
            chk("addr_stable", 64'(mem_addr_out), 64'(a0));
            if (gcnt == 0) begin
               mem_gnt_in = 1'b1;
               in_req     = 1'b0;
               if (exp_mem_q.size() == 0) begin
                  chk("unexp_mreq", 64'(mem_req_out), 64'd0);
               end else begin
                  t = exp_mem_q.pop_front();
                  chk("mem_we", 64'(mem_we_out), 64'(t.we));
                  chk("mem_addr", 64'(mem_addr_out), 64'(t.addr));
                  chk("mem_be", 64'(mem_be_out), 64'(t.be));
                  if (t.we) chk("mem_wdata", 64'(mem_wdata_out), 64'(t.wdata));
               end
               cur = mdl_mem.exists(mem_addr_out) ? mdl_mem[mem_addr_out] : dflt(mem_addr_out);
               if (mem_we_out) begin
                  mdl_mem[mem_addr_out] = merge(cur, mem_wdata_out, mem_be_out);
                  rdv = WR_RESP;
               end else begin
                  rdv = cur;
               end
               rv_pend = 1'b1;
               rcnt    = rv_delay;
            end else begin
               gcnt--;
            end
         end
      end
   end

   // Ack monitor / scoreboard
   initial begin : monitor
      txn_t t;
      forever begin
         @(negedge clk);
         if (rst_n && (if_ack_out || dm_ack_out)) begin
            chk("one_ack", 64'(if_ack_out && dm_ack_out), 64'd0);
            if (exp_ack_q.size() == 0) begin
               chk("unexp_ack", 64'({if_ack_out, dm_ack_out}), 64'd0);
            end else begin
               t = exp_ack_q.pop_front();
               chk("ack_id", 64'(dm_ack_out ? REQ_DM : REQ_IF), 64'(t.id));
               chk("ack_rdata", 64'(dm_ack_out ? dm_rdata_out : if_rdata_out), 64'(t.rdata));
               chk("ack_lat", 64'(cyc - rv_cyc), 64'd1);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          n;
      logic [31:0] if_keep;
      logic [31:0] dm_keep;

      // Reset values, then tie from reset: DM, IF, DM, IF
      preload(32'h20, 32'h1111_2020);
      preload(32'h40, 32'h2222_4040);
      if_addr_in  = 32'h20;
      dm_addr_in  = 32'h40;
      dm_we_in    = 1'b0;
      dm_be_in    = 4'hF;
      if_req_in   = 1'b1;
      dm_req_in   = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mreq", 64'(mem_req_out), 64'd0);
      chk("rst_mwe", 64'(mem_we_out), 64'd0);
      chk("rst_maddr", 64'(mem_addr_out), 64'd0);
      chk("rst_mbe", 64'(mem_be_out), 64'd0);
      chk("rst_acks", 64'({if_ack_out, dm_ack_out}), 64'd0);
      chk("rst_ifrd", 64'(if_rdata_out), 64'd0);
      chk("rst_dmrd", 64'(dm_rdata_out), 64'd0);
      push(REQ_DM, 1'b0, 32'h40, 32'h0, 4'hF);
      push(REQ_IF, 1'b0, 32'h20, 32'h0, 4'hF);
      push(REQ_DM, 1'b0, 32'h40, 32'h0, 4'hF);
      push(REQ_IF, 1'b0, 32'h20, 32'h0, 4'hF);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if (if_ack_out || dm_ack_out) n++;
         if (n == 4) begin
            if_req_in = 1'b0;
            dm_req_in = 1'b0;
         end
      end
      chk("tie_acks", 64'(n), 64'd4);

      // Single fetch, minimum latency, cycle by cycle
      @(negedge clk);
      preload(32'h10, 32'h0051_3093);
      drive(REQ_IF, 1'b0, 32'h10, 32'h0, 4'hF);
      #1;
      chk("c0_stall", 64'(stall_out), 64'd1);
      chk("c0_mreq", 64'(mem_req_out), 64'd0);
      @(negedge clk);
      chk("c1_mreq", 64'(mem_req_out), 64'd1);
      chk("c1_stall", 64'(stall_out), 64'd1);
      @(negedge clk);
      chk("c2_mreq", 64'(mem_req_out), 64'd0);
      chk("c2_stall", 64'(stall_out), 64'd1);
      @(negedge clk);
      chk("c3_ack", 64'(if_ack_out), 64'd1);
      chk("c3_rdata", 64'(if_rdata_out), 64'h0051_3093);
      chk("c3_stall", 64'(stall_out), 64'd0);
      if_req_in = 1'b0;

      // Store with partial byte enables, then read it back
      @(negedge clk);
      preload(32'h100, 32'h1122_3344);
      do_req(REQ_DM, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
      @(negedge clk);
      do_req(REQ_DM, 1'b0, 32'h100, 32'h0, 4'hF);

      // Backpressure: gnt 3 cycles late, rvalid 2 more cycles late
      gnt_delay = 3;
      rv_delay  = 2;
      @(negedge clk);
      do_req(REQ_IF, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
      @(negedge clk);
      do_req(REQ_DM, 1'b0, 32'h0000_0308, 32'h0, 4'h5);
      gnt_delay = 0;

      // Reset while waiting for the response; the late rvalid must be dropped
      rv_delay = 5;
      @(negedge clk);
      drive(REQ_DM, 1'b0, 32'h44, 32'h0, 4'hF);
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         @(negedge clk);
         if (mem_gnt_in) n = 1;
      end
      chk("rst_gnt_seen", 64'(n), 64'd1);
      @(negedge clk);
      rst_n     = 1'b0;
      dm_req_in = 1'b0;
      #1;
      chk("rw_mreq", 64'(mem_req_out), 64'd0);
      chk("rw_maddr", 64'(mem_addr_out), 64'd0);
      chk("rw_mwe", 64'(mem_we_out), 64'd0);
      chk("rw_acks", 64'({if_ack_out, dm_ack_out}), 64'd0);
      chk("rw_ifrd", 64'(if_rdata_out), 64'd0);
      chk("rw_dmrd", 64'(dm_rdata_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ack_q.delete();
      repeat (8) begin
         @(negedge clk);
         chk("rw_no_ack", 64'({if_ack_out, dm_ack_out}), 64'd0);
         chk("rw_no_mreq", 64'(mem_req_out), 64'd0);
      end
      rv_delay = 0;
      do_req(REQ_IF, 1'b0, 32'h10, 32'h0, 4'hF);

      // Stray rvalid while idle
      @(negedge clk);
      if_keep  = if_rdata_out;
      dm_keep  = dm_rdata_out;
      stray_rv = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("stray_ack", 64'({if_ack_out, dm_ack_out}), 64'd0);
         chk("stray_mreq", 64'(mem_req_out), 64'd0);
      end
      chk("stray_ifrd", 64'(if_rdata_out), 64'(if_keep));
      chk("stray_dmrd", 64'(dm_rdata_out), 64'(dm_keep));
      do_req(REQ_DM, 1'b0, 32'h20, 32'h0, 4'hF);

      repeat (3) @(negedge clk);
      chk("ack_q_empty", 64'(exp_ack_q.size()), 64'd0);
      chk("mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external single-port memory between the core's instruction-fetch port and its data load/store port. Two requesters, one memory: at most one transaction in flight, 2-way round-robin arbitration, request/grant/response-valid handshake on the memory side, and a stall signal back to the core until its access completes. Sits between the CPU top level and unified memory, replacing the separate instruction and data memory buses.

## Interface
- ADDR_W, default ARCH (32): address width
- DATA_W, default ARCH (32): data width; byte-enable width is DATA_W/8
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- if_req_in  in  1  fetch request; held until if_ack_out
- if_addr_in  in  ADDR_W  fetch address
- if_rdata_out  out  DATA_W  fetch data; valid only with if_ack_out
- if_ack_out  out  1  one-cycle completion pulse
- dm_req_in  in  1  data request; held until dm_ack_out
- dm_we_in  in  1  1 = store, 0 = load
- dm_addr_in  in  ADDR_W  data address
- dm_wdata_in  in  DATA_W  store data
- dm_be_in  in  DATA_W/8  store byte enables
- dm_rdata_out  out  DATA_W  load data; valid only with dm_ack_out
- dm_ack_out  out  1  one-cycle completion pulse
- mem_req_out  out  1  memory request
- mem_we_out  out  1  memory write enable
- mem_addr_out  out  ADDR_W  memory address
- mem_wdata_out  out  DATA_W  memory write data
- mem_be_out  out  DATA_W/8  memory byte enables
- mem_gnt_in  in  1  memory accepted the request
- mem_rvalid_in  in  1  response valid; also returned for writes
- mem_rdata_in  in  DATA_W  response data
- stall_out  out  1  core must hold state

## Operation
- FSM states ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_ACK.
- ARB_IDLE: if any request is pending, arbitrate, latch the owner and the owner's addr/we/wdata/be into the mem_* output registers, and go to ARB_REQ. Otherwise stay.
- Arbitration:
  - One request only: grant it.
  - Both requesting: grant the requester not granted last.
  - last_grant resets to IF, so the first tie goes to DM.
  - last_grant updates on every grant.
- Fetch transactions drive mem_we_out=0 and mem_be_out all ones.
- ARB_REQ: mem_req_out=1. When mem_gnt_in=1, go to ARB_WAIT.
- ARB_WAIT: mem_req_out=0. On mem_rvalid_in=1, capture mem_rdata_in into the owner's rdata register and go to ARB_ACK.
- ARB_ACK: assert the owner's ack for this cycle only, then go to ARB_IDLE. No arbitration in this state, because the owner's req is still high for the finished transaction.
- rdata_out registers hold their value until the next capture.
- stall_out = (if_req_in & ~if_ack_out) | (dm_req_in & ~dm_ack_out), combinational.
- Ignored inputs:
  - mem_rvalid_in outside ARB_WAIT, including stray responses after reset.
  - mem_gnt_in outside ARB_REQ.
- A requester dropping req before its ack is a protocol violation. The transaction still completes; its ack pulse is still generated.

## Timing
- Reset (async, immediate): state ARB_IDLE; all mem_* outputs 0; both acks 0; both rdata 0; last_grant = IF.
- Reset mid-transaction: the transaction is abandoned with no ack, and any late response is dropped.
- Minimum latency: req at cycle 0, mem_req_out cycle 1 (gnt same cycle), rvalid cycle 2, ack cycle 3.
- Each cycle mem_gnt_in is low extends ARB_REQ by one cycle; each cycle without rvalid extends ARB_WAIT by one cycle.
- Best-case throughput is one transaction per 4 cycles. Back-to-back: the next grant is taken in the ARB_IDLE cycle after ARB_ACK.
- mem_addr/we/wdata/be are stable from entering ARB_REQ until the return to ARB_IDLE.

## Structure
- friscv_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_ACK}
  - typedef enum logic req_id_t {REQ_IF, REQ_DM}
- Sub-module rr_arbiter_2 contains the combinational grant logic plus the last_grant register, with inputs req[1:0] and grant_en and output req_id_t grant.

## Test plan
- Single fetch: if_req_in=1, addr 0x0000_0010; memory gnt immediately, rdata 0x0051_3093 one cycle later. Expect mem_req_out at cycle 1, if_ack_out at cycle 3 with if_rdata_out=0x0051_3093, and stall_out high in cycles 0–2.
- Tie: both requesters high from reset. Expect grant order DM, IF, DM, IF over four transactions.
- Store: dm_we_in=1, addr 0x100, wdata 0xDEAD_BEEF, be 0b0011. Expect mem_we_out=1 with matching addr/wdata/be, and dm_ack_out after rvalid.
- Backpressure: gnt delayed 3 cycles, rvalid delayed 2 more. Expect mem_req_out held high with stable address until gnt, and ack exactly one cycle after rvalid.
- Reset in ARB_WAIT: rst_n low for one cycle, then a late rvalid. Expect no ack, outputs at reset values, and the next request served normally.
- Stray rvalid in ARB_IDLE: expect no state change and no ack.
